// File: rtl/decryption_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : decryption_sequencer
// Purpose  : Front-end controller for the decryption datapath. Accepts one
//            character stream, steers each message to one of three engines
//            (0 = caesar, 1 = scytale, 2 = zigzag), holds off upstream while
//            the engine decrypts, and merges the selected engine output into
//            one registered stream. Flags invalid selects, overlong messages
//            and engine timeouts.
// Ports    : clk, rst_n (sync, active-low)
//            data_i/valid_i/sel_i  -> upstream character stream + select
//            busy_o                -> upstream back-pressure
//            eng_data_o/eng_valid_o-> shared bus + one-hot valid to engines
//            eng_busy_i/eng_data_i/eng_valid_i <- per-engine status/output
//            data_o/valid_o/done_o -> merged decrypted stream, end pulse
//            err_o                 -> sticky {timeout, overflow, bad select}
// Revision : 1.0 - initial release
// ============================================================================
module decryption_sequencer #(
  parameter int                  D_WIDTH                = 8,
  parameter int                  MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0]  START_DECRYPTION_TOKEN = 8'hFA,
  parameter int                  TIMEOUT                = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [D_WIDTH-1:0]     data_i,
  input  logic                   valid_i,
  input  logic [1:0]             sel_i,
  output logic                   busy_o,
  output logic [D_WIDTH-1:0]     eng_data_o,
  output logic [2:0]             eng_valid_o,
  input  logic [2:0]             eng_busy_i,
  input  logic [3*D_WIDTH-1:0]   eng_data_i,
  input  logic [2:0]             eng_valid_i,
  output logic [D_WIDTH-1:0]     data_o,
  output logic                   valid_o,
  output logic                   done_o,
  output logic [2:0]             err_o
);

  localparam logic [2:0]  c_IDLE     = 3'd0;
  localparam logic [2:0]  c_LOAD     = 3'd1;
  localparam logic [2:0]  c_WAIT_ENG = 3'd2;
  localparam logic [2:0]  c_DRAIN    = 3'd3;
  localparam logic [2:0]  c_DONE     = 3'd4;

  localparam logic [7:0]  c_CNT_MAX    = 8'(MAX_NOF_CHARS);
  localparam logic [15:0] c_TIMER_LAST = 16'(TIMEOUT - 1);

  logic [2:0]         r_state;
  logic [1:0]         r_sel;
  logic [7:0]         r_cnt;
  logic [15:0]        r_timer;
  logic               r_busy;
  logic [D_WIDTH-1:0] r_eng_data;
  logic [2:0]         r_eng_valid;
  logic [D_WIDTH-1:0] r_data;
  logic               r_valid;
  logic               r_done;
  logic [2:0]         r_err;

  logic               w_is_token;
  logic [D_WIDTH-1:0] w_sel_data;
  logic               w_sel_valid;
  logic               w_sel_busy;

  assign w_is_token = (data_i == START_DECRYPTION_TOKEN);

  // Engine return mux keyed on the latched select; unselected engines are
  // invisible, and select 3 (never latched past IDLE) reads as idle/empty.
  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    w_sel_busy  = 1'b0;
    case (r_sel)
      2'd0: begin
        w_sel_data  = eng_data_i[0 +: D_WIDTH];
        w_sel_valid = eng_valid_i[0];
        w_sel_busy  = eng_busy_i[0];
      end
      2'd1: begin
        w_sel_data  = eng_data_i[D_WIDTH +: D_WIDTH];
        w_sel_valid = eng_valid_i[1];
        w_sel_busy  = eng_busy_i[1];
      end
      2'd2: begin
        w_sel_data  = eng_data_i[2*D_WIDTH +: D_WIDTH];
        w_sel_valid = eng_valid_i[2];
        w_sel_busy  = eng_busy_i[2];
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= c_IDLE;
      r_sel       <= 2'd0;
      r_cnt       <= 8'd0;
      r_timer     <= 16'd0;
      r_busy      <= 1'b0;
      r_eng_data  <= '0;
      r_eng_valid <= 3'b000;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 3'b000;
    end else begin
      // Single-cycle strobes default low; eng_data_o and data_o hold.
      r_eng_valid <= 3'b000;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;

      case (r_state)
        c_IDLE: begin
          if (valid_i) begin
            r_err <= 3'b000;
            r_sel <= sel_i;
            if (sel_i == 2'd3) begin
              // Later bit assignment wins over the clear above.
              r_err[0] <= 1'b1;
            end else begin
              // sel_q is not yet visible, so steer with sel_i directly.
              r_eng_data  <= data_i;
              r_eng_valid <= 3'b001 << sel_i;
              if (w_is_token) begin
                r_timer <= 16'd0;
                r_busy  <= 1'b1;
                r_state <= c_WAIT_ENG;
              end else begin
                r_cnt   <= 8'd1;
                r_state <= c_LOAD;
              end
            end
          end
        end

        c_LOAD: begin
          if (valid_i) begin
            if (w_is_token) begin
              // The token is forwarded even when the count is saturated.
              r_eng_data  <= data_i;
              r_eng_valid <= 3'b001 << r_sel;
              r_timer     <= 16'd0;
              r_busy      <= 1'b1;
              r_state     <= c_WAIT_ENG;
            end else if (r_cnt < c_CNT_MAX) begin
              r_eng_data  <= data_i;
              r_eng_valid <= 3'b001 << r_sel;
              r_cnt       <= r_cnt + 8'd1;
            end else begin
              r_err[1] <= 1'b1;
            end
          end
        end

        c_WAIT_ENG: begin
          if (w_sel_busy) begin
            r_state <= c_DRAIN;
          end else if (r_timer == c_TIMER_LAST) begin
            r_err[2] <= 1'b1;
            r_state  <= c_DONE;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end

        c_DRAIN: begin
          r_data  <= w_sel_data;
          r_valid <= w_sel_valid;
          if (!w_sel_busy) begin
            r_state <= c_DONE;
          end
        end

        c_DONE: begin
          // One more capture for engines whose last beat lines up with
          // busy falling.
          r_data  <= w_sel_data;
          r_valid <= w_sel_valid;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_cnt   <= 8'd0;
          r_state <= c_IDLE;
        end

        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign eng_data_o  = r_eng_data;
  assign eng_valid_o = r_eng_valid;
  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign done_o      = r_done;
  assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_decryption_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_decryption_sequencer
// Purpose  : Directed self-checking bench for decryption_sequencer. A second
//            instance with MAX_NOF_CHARS=4 covers the overflow path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decryption_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  data_i;
  logic        valid_i;
  logic [1:0]  sel_i;
  logic        busy_o;
  logic [7:0]  eng_data_o;
  logic [2:0]  eng_valid_o;
  logic [2:0]  eng_busy_i;
  logic [23:0] eng_data_i;
  logic [2:0]  eng_valid_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        done_o;
  logic [2:0]  err_o;

  logic [7:0]  b_data_i;
  logic        b_valid_i;
  logic [1:0]  b_sel_i;
  logic        b_busy_o;
  logic [7:0]  b_eng_data_o;
  logic [2:0]  b_eng_valid_o;
  logic [2:0]  b_eng_busy_i;
  logic [23:0] b_eng_data_i;
  logic [2:0]  b_eng_valid_i;
  logic [7:0]  b_data_o;
  logic        b_valid_o;
  logic        b_done_o;
  logic [2:0]  b_err_o;

  decryption_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .sel_i       (sel_i),
    .busy_o      (busy_o),
    .eng_data_o  (eng_data_o),
    .eng_valid_o (eng_valid_o),
    .eng_busy_i  (eng_busy_i),
    .eng_data_i  (eng_data_i),
    .eng_valid_i (eng_valid_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  decryption_sequencer #(.MAX_NOF_CHARS(4)) dut_ovf (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_i      (b_data_i),
    .valid_i     (b_valid_i),
    .sel_i       (b_sel_i),
    .busy_o      (b_busy_o),
    .eng_data_o  (b_eng_data_o),
    .eng_valid_o (b_eng_valid_o),
    .eng_busy_i  (b_eng_busy_i),
    .eng_data_i  (b_eng_data_i),
    .eng_valid_i (b_eng_valid_i),
    .data_o      (b_data_o),
    .valid_o     (b_valid_o),
    .done_o      (b_done_o),
    .err_o       (b_err_o)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] msg [6];
  logic [7:0] dec [6];

  initial begin
    msg = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    dec = '{8'h41, 8'h43, 8'h45, 8'h42, 8'h44, 8'h46};

    rst_n = 1'b0; data_i = '0; valid_i = 1'b0; sel_i = '0;
    eng_busy_i = '0; eng_data_i = '0; eng_valid_i = '0;
    b_data_i = '0; b_valid_i = 1'b0; b_sel_i = '0;
    b_eng_busy_i = '0; b_eng_data_i = '0; b_eng_valid_i = '0;
    step(); step();

    // Reset state
    chk("rst_busy",      32'(busy_o), 0);
    chk("rst_valid",     32'(valid_o), 0);
    chk("rst_done",      32'(done_o), 0);
    chk("rst_err",       32'(err_o), 0);
    chk("rst_eng_valid", 32'(eng_valid_o), 0);
    chk("rst_data",      32'(data_o), 0);
    rst_n = 1'b1;
    step();

    // Scytale message
    sel_i = 2'd1; valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_i = msg[i];
      step();
      chk("scy_fwd_valid", 32'(eng_valid_o), 'h2);
      chk("scy_fwd_data",  32'(eng_data_o), 32'(msg[i]));
      chk("scy_busy_load", 32'(busy_o), 0);
    end
    data_i = 8'hFA;
    step();
    chk("scy_tok_valid", 32'(eng_valid_o), 'h2);
    chk("scy_tok_data",  32'(eng_data_o), 'hFA);
    chk("scy_busy_rise", 32'(busy_o), 1);
    valid_i = 1'b0;
    step();
    chk("scy_busy_wait", 32'(busy_o), 1);
    chk("scy_fwd_idle",  32'(eng_valid_o), 0);
    eng_busy_i = 3'b010;
    step();
    chk("scy_no_out_yet", 32'(valid_o), 0);
    for (int i = 0; i < 6; i++) begin
      eng_data_i[8 +: 8] = dec[i];
      eng_valid_i = 3'b010;
      if (i == 5) eng_busy_i = 3'b000;
      step();
      chk("scy_out_valid", 32'(valid_o), 1);
      chk("scy_out_data",  32'(data_o), 32'(dec[i]));
      chk("scy_out_done",  32'(done_o), 0);
      chk("scy_out_busy",  32'(busy_o), 1);
    end
    eng_valid_i = 3'b000;
    step();
    chk("scy_done",       32'(done_o), 1);
    chk("scy_busy_fall",  32'(busy_o), 0);
    chk("scy_valid_end",  32'(valid_o), 0);
    chk("scy_err",        32'(err_o), 0);
    step();
    chk("scy_done_once",  32'(done_o), 0);

    // Select latch and isolation
    sel_i = 2'd0; valid_i = 1'b1; data_i = 8'h11;
    step();
    chk("lat_first", 32'(eng_valid_o), 'h1);
    sel_i = 2'd2; data_i = 8'h22;
    step();
    chk("lat_second",      32'(eng_valid_o), 'h1);
    chk("lat_second_data", 32'(eng_data_o), 'h22);
    data_i = 8'hFA;
    step();
    chk("lat_token", 32'(eng_valid_o), 'h1);
    valid_i = 1'b0;
    eng_busy_i = 3'b101; eng_valid_i = 3'b100; eng_data_i[16 +: 8] = 8'hEE;
    step();
    eng_valid_i = 3'b101; eng_data_i[0 +: 8] = 8'h51;
    step();
    chk("iso_valid", 32'(valid_o), 1);
    chk("iso_data",  32'(data_o), 'h51);
    eng_valid_i = 3'b100; eng_busy_i = 3'b100;
    step();
    chk("iso_drop_valid", 32'(valid_o), 0);
    chk("iso_drop_data",  32'(data_o), 'h51);
    step();
    chk("iso_done",       32'(done_o), 1);
    chk("iso_done_valid", 32'(valid_o), 0);
    eng_busy_i = '0; eng_valid_i = '0; eng_data_i = '0;
    step();

    // Invalid select
    sel_i = 2'd3; valid_i = 1'b1; data_i = 8'h41;
    step();
    chk("inv_err",       32'(err_o), 'h1);
    chk("inv_no_fwd",    32'(eng_valid_o), 0);
    chk("inv_busy",      32'(busy_o), 0);
    valid_i = 1'b0;
    step();
    chk("inv_sticky",    32'(err_o), 'h1);
    sel_i = 2'd2; valid_i = 1'b1; data_i = 8'h5A;
    step();
    chk("inv_clear",     32'(err_o), 0);
    chk("inv_next_fwd",  32'(eng_valid_o), 'h4);
    data_i = 8'hFA;
    step();
    chk("inv_next_tok",  32'(eng_valid_o), 'h4);
    valid_i = 1'b0;
    step();
    eng_busy_i = 3'b100;
    step();
    eng_busy_i = 3'b000;
    step();
    chk("lat4_not_yet",  32'(done_o), 0);
    step();
    chk("lat4_done",     32'(done_o), 1);
    step();

    // Overflow (MAX_NOF_CHARS = 4)
    b_sel_i = 2'd0; b_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b_data_i = 8'h30 + 8'(i);
      step();
      chk("ovf_fwd", 32'(b_eng_valid_o), (i < 4) ? 1 : 0);
      chk("ovf_err", 32'(b_err_o), (i < 4) ? 0 : 2);
    end
    chk("ovf_hold_data", 32'(b_eng_data_o), 'h33);
    b_data_i = 8'hFA;
    step();
    chk("ovf_tok_fwd",  32'(b_eng_valid_o), 'h1);
    chk("ovf_tok_data", 32'(b_eng_data_o), 'hFA);
    b_valid_i = 1'b0;
    b_eng_busy_i = 3'b001;
    step();
    b_eng_busy_i = 3'b000;
    step();
    step();
    chk("ovf_done",     32'(b_done_o), 1);
    chk("ovf_err_keep", 32'(b_err_o), 'h2);
    chk("ovf_busy",     32'(b_busy_o), 0);

    // Timeout
    sel_i = 2'd1; data_i = 8'hFA; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk("to_busy", 32'(busy_o), 1);
    for (int k = 1; k < 16; k++) begin
      step();
      chk("to_err_early", 32'(err_o), 0);
      chk("to_no_valid",  32'(valid_o), 0);
    end
    step();
    chk("to_err",        32'(err_o), 'h4);
    chk("to_busy_hold",  32'(busy_o), 1);
    chk("to_done_early", 32'(done_o), 0);
    step();
    chk("to_done",       32'(done_o), 1);
    chk("to_busy_fall",  32'(busy_o), 0);
    chk("to_valid",      32'(valid_o), 0);
    step();

    // Reset mid-DRAIN
    sel_i = 2'd1; valid_i = 1'b1; data_i = 8'h41;
    step();
    data_i = 8'hFA;
    step();
    valid_i = 1'b0; eng_busy_i = 3'b010;
    step();
    eng_valid_i = 3'b010; eng_data_i[8 +: 8] = 8'h77;
    step();
    chk("mr_pre_valid", 32'(valid_o), 1);
    chk("mr_pre_data",  32'(data_o), 'h77);
    rst_n = 1'b0;
    step();
    chk("mr_data",  32'(data_o), 0);
    chk("mr_valid", 32'(valid_o), 0);
    chk("mr_busy",  32'(busy_o), 0);
    chk("mr_done",  32'(done_o), 0);
    chk("mr_err",   32'(err_o), 0);
    rst_n = 1'b1; eng_busy_i = '0; eng_valid_i = '0; eng_data_i = '0;
    step();

    sel_i = 2'd1; valid_i = 1'b1; data_i = 8'h50;
    step();
    chk("fr_fwd0", 32'(eng_valid_o), 'h2);
    data_i = 8'h51;
    step();
    chk("fr_fwd1", 32'(eng_valid_o), 'h2);
    data_i = 8'hFA;
    step();
    chk("fr_tok",  32'(eng_valid_o), 'h2);
    chk("fr_busy", 32'(busy_o), 1);
    valid_i = 1'b0; eng_busy_i = 3'b010;
    step();
    eng_valid_i = 3'b010; eng_data_i[8 +: 8] = 8'h51;
    step();
    chk("fr_out0", 32'(data_o), 'h51);
    eng_data_i[8 +: 8] = 8'h50; eng_busy_i = 3'b000;
    step();
    chk("fr_out1_valid", 32'(valid_o), 1);
    chk("fr_out1",       32'(data_o), 'h50);
    eng_valid_i = 3'b000;
    step();
    chk("fr_done",  32'(done_o), 1);
    chk("fr_err",   32'(err_o), 0);
    chk("fr_valid", 32'(valid_o), 0);
    step();
    chk("fr_done_once", 32'(done_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
